// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
//   - funct3 encodings of the eight M-extension operations
//   - FSM state encoding (IDLE, MUL, DIV, FIX, DONE)
//   - INT_MIN, the one signed dividend that can overflow
//   - small decode helpers on funct3
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  // Every divider op has funct3[2] set.
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // Among divider ops, REM/REMU have funct3[1] set.
  function automatic logic is_rem(input logic [2:0] f3);
    return f3[1];
  endfunction

  // Among divider ops, the signed ones (DIV/REM) have funct3[0] clear.
  function automatic logic is_signed_div(input logic [2:0] f3);
    return ~f3[0];
  endfunction

endpackage

// File: rtl/mul_pipe.sv
// Pipelined 33x33 signed multiplier.
//   clk      clock
//   rst_i    synchronous active-high reset (clears the valid pipe only)
//   flush_i  kills every product in flight
//   valid_i  operands on a_i/b_i are to be multiplied
//   a_i,b_i  33-bit signed operands (already sign/zero extended)
//   valid_o  prod_o holds a product, LATENCY cycles after valid_i
//   prod_o   low 64 bits of the 66-bit product (all the sequencer reads)
module mul_pipe #(
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               valid_i,
  input  logic signed [32:0] a_i,
  input  logic signed [32:0] b_i,
  output logic               valid_o,
  output logic [63:0]        prod_o
);

  logic [LATENCY-1:0] vld_q;
  logic [63:0]        prod_q [LATENCY];

  // NOTE: sequential state is always written with non-blocking assignments
  // so every stage samples its predecessor's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst_i || flush_i) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= valid_i;
      for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // The size casts sign-extend; the low 64 bits of the truncated product
  // equal the low 64 bits of the true 66-bit product.
  always_ff @(posedge clk) begin
    prod_q[0] <= 64'(a_i) * 64'(b_i);
    for (int i = 1; i < LATENCY; i++) prod_q[i] <= prod_q[i-1];
  end

  assign valid_o = vld_q[LATENCY-1];
  assign prod_o  = prod_q[LATENCY-1];

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M execute-stage sequencer: drives the pipelined multiplier and an
// inline radix-2 restoring divider, stalls the front end while busy and
// presents one result per op.
//   clk, rst          clock, synchronous active-high reset
//   start, funct3     M-extension op valid in EX and its encoding
//   rs1_val, rs2_val  forwarded operands
//   rd_in             destination register
//   flush             kill the op in flight / the completing op
//   stall             hold PC, IF/ID, ID/EX
//   done              one-cycle result valid
//   result, rd_out    result and destination, valid with done
//   reg_write         done && rd_out != 0
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            reg_write
);

  logic [2:0]  state_q, state_d;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, res_d;
  logic        done_q, reg_write_q;

  logic        a_neg_q, b_neg_q;
  logic [31:0] divisor_q, quo_q, rem_q;
  logic [4:0]  cnt_q;

  // Accept decode
  logic accept, op_div, sgn_div, dbz, ovf, special;
  logic [31:0] special_res;

  assign accept  = start && (state_q == S_IDLE) && !flush;
  assign op_div  = is_div(funct3);
  assign sgn_div = op_div && is_signed_div(funct3);
  assign dbz     = (rs2_val == '0);
  assign ovf     = sgn_div && (rs1_val == INT_MIN) && (rs2_val == '1);
  assign special = op_div && (dbz || ovf);

  always_comb begin
    special_res = '0;
    if (dbz) special_res = is_rem(funct3) ? rs1_val : '1;
    else     special_res = is_rem(funct3) ? '0 : INT_MIN;
  end

  // Multiplier: rs1 is signed except for MULHU, rs2 only for MUL/MULH.
  logic               a_sx, b_sx, mul_vld;
  logic signed [32:0] mul_a, mul_b;
  logic [63:0]        mul_prod;

  assign a_sx  = (funct3[1:0] != 2'b11);
  assign b_sx  = ~funct3[1];
  assign mul_a = {a_sx & rs1_val[31], rs1_val};
  assign mul_b = {b_sx & rs2_val[31], rs2_val};

  mul_pipe #(.LATENCY(MUL_LATENCY)) u_mul_pipe (
    .clk     (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .valid_i (accept && !op_div),
    .a_i     (mul_a),
    .b_i     (mul_b),
    .valid_o (mul_vld),
    .prod_o  (mul_prod)
  );

  // Divider step: shift the next dividend bit into the partial remainder
  // and subtract; a clear borrow bit means the quotient bit is 1.
  logic [32:0] rem_shift, diff;
  logic        ge;
  logic [31:0] quo_fix, rem_fix;

  assign rem_shift = {rem_q, quo_q[31]};
  assign diff      = rem_shift - {1'b0, divisor_q};
  assign ge        = ~diff[32];
  assign quo_fix   = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
  assign rem_fix   = a_neg_q ? -rem_q : rem_q;

  // NOTE: every always_comb output gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = special ? S_DONE : (op_div ? S_DIV : S_MUL);
      S_MUL:  if (flush) state_d = S_IDLE; else if (mul_vld) state_d = S_DONE;
      S_DIV:  if (flush) state_d = S_IDLE; else if (cnt_q == 5'd31) state_d = S_FIX;
      S_FIX:  state_d = flush ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res_d = result_q;
    if (state_d == S_DONE) begin
      case (state_q)
        S_IDLE:  res_d = special_res;
        S_MUL:   res_d = (f3_q == F3_MUL) ? mul_prod[31:0] : mul_prod[63:32];
        S_FIX:   res_d = is_rem(f3_q) ? rem_fix : quo_fix;
        default: res_d = result_q;
      endcase
    end
  end

  assign rd_d = accept ? rd_in : rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      f3_q        <= F3_MUL;
      rd_q        <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (accept) f3_q <= funct3;
      rd_q        <= rd_d;
      result_q    <= res_d;
      done_q      <= (state_d == S_DONE);
      reg_write_q <= (state_d == S_DONE) && (rd_d != '0);
    end
  end

  // NOTE: divider datapath registers carry no reset; they are always
  // loaded on accept before being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_neg_q   <= sgn_div & rs1_val[31];
      b_neg_q   <= sgn_div & rs2_val[31];
      quo_q     <= (sgn_div & rs1_val[31]) ? -rs1_val : rs1_val;
      divisor_q <= (sgn_div & rs2_val[31]) ? -rs2_val : rs2_val;
      rem_q     <= '0;
      cnt_q     <= '0;
    end else if (state_q == S_DIV) begin
      quo_q <= {quo_q[30:0], ge};
      rem_q <= ge ? diff[31:0] : rem_shift[31:0];
      cnt_q <= cnt_q + 5'd1;
    end
  end

  // stall is low in DONE so the completing instruction advances this cycle.
  assign stall     = !rst && ((state_q == S_MUL) || (state_q == S_DIV) ||
                              (state_q == S_FIX) || accept);
  assign done      = done_q && !flush;
  assign reg_write = reg_write_q && !flush;
  assign result    = result_q;
  assign rd_out    = rd_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl (MUL_LATENCY = 2).
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val, result;
  logic [4:0]  rd_in, rd_out;
  logic        stall, done, reg_write;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wr;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  muldiv_ctrl #(.XLEN(32), .MUL_LATENCY(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .rd_in     (rd_in),
    .flush     (flush),
    .stall     (stall),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .reg_write (reg_write)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
    end
  endtask

  // The pipeline is stalled while an op is in flight, so EX must never
  // present start outside IDLE.
  always @(posedge clk) begin
    if (!rst && start) begin
      assert (dut.state_q == S_IDLE)
      else begin
        n_fail++;
        $display("FAIL start_outside_idle: got state %0d, expected %0d", dut.state_q, S_IDLE);
      end
    end
  end

  // Monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 result=0x%08h, expected no done", result);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_rd"}, 32'(rd_out), 32'(e.rd));
        check({e.name, "_reg_write"}, 32'(reg_write), 32'(e.wr));
        check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Drives start for one cycle (cycle t); returns at the negedge of t+1.
  task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                       input int lat, input bit expect_done, output int t);
    exp_t e;
    @(negedge clk);
    start = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b; rd_in = rd;
    t = cyc;
    if (expect_done) begin
      e.name = name; e.res = exp_res; e.rd = rd; e.wr = (rd != 5'd0); e.cyc = t + lat;
      sb_q.push_back(e);
    end
    #1 check({name, "_stall_at_accept"}, 32'(stall), 32'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic run(input string name, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                     input int lat);
    int t;
    issue(name, f3, a, b, rd, exp_res, lat, 1'b1, t);
    wait_drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst = 1'b1; start = 1'b1; flush = 1'b0; funct3 = F3_MUL;
    rs1_val = 32'd5; rs2_val = 32'd7; rd_in = 5'd1;
    repeat (2) @(negedge clk);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd", 32'(rd_out), 32'd0);
    check("reset_reg_write", 32'(reg_write), 32'd0);
    rst = 1'b0; start = 1'b0;

    // MUL with stall profile: high T..T+2, low at T+3 (done cycle).
    issue("mul", F3_MUL, 32'd256, 32'd256, 5'd5, 32'h0001_0000, 3, 1'b1, t);
    check("mul_stall_t1", 32'(stall), 32'd1);
    @(negedge clk);
    check("mul_stall_t2", 32'(stall), 32'd1);
    @(negedge clk);
    check("mul_stall_t3", 32'(stall), 32'd0);
    wait_drain();

    run("mulh",     F3_MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd6,  32'h3FFF_FFFF, 3);
    run("mulhu",    F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 3);
    run("mulhsu",   F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 3);
    run("div_neg",  F3_DIV,    32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 34);
    run("rem_neg",  F3_REM,    32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 34);
    run("divu",     F3_DIVU,   32'd100,       32'd7,         5'd11, 32'd14,        34);
    run("remu",     F3_REMU,   32'd100,       32'd7,         5'd12, 32'd2,         34);
    run("rem_nb",   F3_REM,    32'd7,         32'hFFFF_FFFE, 5'd17, 32'd1,         34);
    run("div_by0",  F3_DIV,    32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1);
    run("remu_by0", F3_REMU,   32'd5,         32'd0,         5'd14, 32'd5,         1);
    run("div_ovf",  F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
    run("rem_ovf",  F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1);
    run("mul_rd0",  F3_MUL,    32'd2,         32'd3,         5'd0,  32'd6,         3);

    // Flush a DIV at T+10: no done, stall low at T+11, MUL at T+12 done T+15.
    issue("div_flushed", F3_DIV, 32'd1000, 32'd3, 5'd18, 32'd0, 34, 1'b0, t);
    while (cyc < t + 10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1 check("stall_after_flush", 32'(stall), 32'd0);
    issue("mul_after_flush", F3_MUL, 32'd3, 32'd4, 5'd19, 32'd12, 3, 1'b1, t);
    wait_drain();

    // Flush during DONE suppresses done and reg_write.
    @(negedge clk);
    start = 1'b1; funct3 = F3_DIV; rs1_val = 32'd5; rs2_val = 32'd0; rd_in = 5'd20;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b1;
    #1 check("flush_done_done", 32'(done), 32'd0);
    check("flush_done_reg_write", 32'(reg_write), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;

    // Reset in the middle of a DIV.
    issue("div_reset", F3_DIVU, 32'd1000, 32'd3, 5'd21, 32'd0, 34, 1'b0, t);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1 check("mid_reset_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_reset_stall", 32'(stall), 32'd0);
    check("post_reset_result", result, 32'd0);
    check("post_reset_reg_write", 32'(reg_write), 32'd0);
    repeat (40) @(negedge clk);
    check("post_reset_done", 32'(done), 32'd0);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer for the RV32M execute-stage datapath. Accepts MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operations from EX and drives a shared pipelined multiplier and an iterative radix-2 divider. While an operation is in flight it stalls IF/ID/EX, then presents one result with its destination register for the EX/MEM latch.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
MUL_LATENCY, 2, register stages in the multiplier sub-module (legal 1..4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  EX holds a valid M-extension op this cycle
funct3  in  3  op select (000 MUL … 111 REMU, RISC-V encoding)
rs1_val  in  32  forwarded operand A
rs2_val  in  32  forwarded operand B
rd_in  in  5  destination register of the op
flush  in  1  kill in-flight op (branch/jump flush of EX)
stall  out  1  hold PC, IF/ID and ID/EX registers
done  out  1  one-cycle result-valid pulse
result  out  32  result, valid when done=1
rd_out  out  5  destination register, valid when done=1
reg_write  out  1  done && rd_out != 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. Reset forces state IDLE and clears all registered outputs: done=0, result=0, rd_out=0, reg_write=0. stall=0 during reset.
- States and transitions:
  - IDLE
  - MUL: counts MUL_LATENCY cycles.
  - DIV: 32 iterations, counter 0..31.
  - FIX: sign correction.
  - DONE: one cycle, then back to IDLE.
- Accept: the op is accepted when start=1, state=IDLE and flush=0. On accept, latch funct3, rd_in and the operands.
- Multiplier ops:
  - Operands are extended to 33 bits: signed for MUL/MULH and for rs1 of MULHSU; zero-extended otherwise.
  - Product is 66 bits. MUL returns bits [31:0]; the MULH variants return bits [63:32].
  - Path: IDLE→MUL, MUL→DONE once MUL_LATENCY cycles have elapsed.
  - Start at cycle T gives done at T+MUL_LATENCY+1.
- Divider ops:
  - Signed ops take operand magnitudes and record the quotient and remainder signs. Restoring division, one quotient bit per cycle.
  - Path: IDLE→DIV (32 cycles)→FIX→DONE, so done at T+34.
  - FIX negates the quotient if sign(a)≠sign(b); negates the remainder if a<0.
- Special cases (detected at accept, IDLE→DONE directly, done at T+1):
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = rs1.
  - DIV/REM with 0x80000000 / -1: quotient = 0x80000000, remainder = 0.
- stall:
  - = (state∈{MUL,DIV,FIX}) || (start && state==IDLE && !flush).
  - Low in DONE, so the instruction advances with the result that same cycle.
- flush:
  - In MUL/DIV/FIX: go to IDLE next cycle, no done pulse, stall drops that cycle.
  - In DONE: suppress done and reg_write.
  - Simultaneous with start: start is ignored.
- start outside IDLE: ignored. The pipeline is stalled, so this is illegal; the bench asserts it never occurs.
- Back-to-back: a new start is accepted in the cycle after DONE. start during DONE is ignored, since EX then holds the completing op.
- Outputs: result, rd_out and reg_write are registered and are held (don't-care) when done=0.

Decomposition:
- muldiv_pkg:
  - funct3 constants F3_MUL…F3_REMU
  - state encoding (IDLE, MUL, DIV, FIX, DONE)
  - INT_MIN constant
  - helper is_div(funct3)=funct3[2]
- Sub-module mul_pipe: 33×33 signed multiplier with MUL_LATENCY output register stages and a valid shift register. The divider datapath (remainder, quotient and counter registers) stays inline in muldiv_ctrl.

Test Plan:
- MUL 256×256, MUL_LATENCY=2, start at T → done at T+3, result 0x00010000, stall high T..T+2.
- MULH 0x7FFFFFFF×0x7FFFFFFF → 0x3FFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU (-1)×0xFFFFFFFF → 0xFFFFFFFF.
- Signed division, start at T:
  - DIV -7/2 → 0xFFFFFFFD (-3), done at T+34.
  - REM -7/2 → 0xFFFFFFFF (-1).
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- Special cases, start at T:
  - DIV 5/0 → 0xFFFFFFFF, done at T+1.
  - REMU 5/0 → 5.
  - DIV 0x80000000/-1 → 0x80000000.
  - REM same operands → 0.
- Flush: flush at T+10 of a DIV → no done pulse, stall=0 from T+11; MUL 3×4 started at T+12 → done at T+15, result 12.
- rd_in=0 with MUL 2×3 → done=1, result 6, reg_write=0. rst asserted mid-DIV → state IDLE, stall=0, no done afterward.
